// File: rtl/vx_imem_responder.sv
// Generic single-clock FIFO used to park completed read responses.
// Latency: a pushed entry is visible at head_dat in the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module vx_imem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign head_dat = store[rd_ptr];

    // Entry storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            store[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking, wrapping at DEPTH-1 so non power-of-two depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push_vld && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop_vld && empty));
endmodule

// Instruction memory responder: byte-enabled writes, tagged in-order read responses.
// Latency: read data and tag appear LATENCY cycles after the read is accepted.
// Backpressure: completed reads park in a RSP_QUEUE FIFO; req_ready drops once RSP_QUEUE reads are outstanding.
module vx_imem_responder #(
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int RSP_QUEUE  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    input  logic                             req_rw,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [WORD_SIZE-1:0]             req_byteen,
    input  logic [8*WORD_SIZE-1:0]           req_data,
    input  logic [TAG_WIDTH-1:0]             req_tag,
    output logic                             req_ready,
    output logic                             rsp_valid,
    output logic [8*WORD_SIZE-1:0]           rsp_data,
    output logic [TAG_WIDTH-1:0]             rsp_tag,
    input  logic                             rsp_ready,
    output logic [$clog2(RSP_QUEUE+1)-1:0]   outstanding,
    output logic                             oob_err
);
    localparam int DW = 8 * WORD_SIZE;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RSP_QUEUE + 1);

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [DW-1:0]        dat;
    } rsp_ent_t;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic          oob;
    logic          rd_fire;
    logic          wr_fire;
    logic          rsp_fire;

    logic [LATENCY:1] stg_vld;
    rsp_ent_t         stg_ent [1:LATENCY];

    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_empty;
    rsp_ent_t fifo_head;
    rsp_ent_t out_ent;

    // Split the word address into the storage index and the out-of-range upper bits.
    generate
        if (ADDR_WIDTH > AW) begin : g_oob
            assign idx = req_addr[AW-1:0];
            assign oob = |req_addr[ADDR_WIDTH-1:AW];
        end else begin : g_no_oob
            assign idx = AW'(req_addr);
            assign oob = 1'b0;
        end
    endgenerate

    assign req_ready = (outstanding < CW'(RSP_QUEUE));
    assign rd_fire   = req_valid && req_ready && !req_rw;
    assign wr_fire   = req_valid && req_ready && req_rw;

    // The FIFO holds older responses, so it has priority; an empty FIFO lets the pipe tail bypass it.
    assign rsp_valid = !fifo_empty || stg_vld[LATENCY];
    assign out_ent   = fifo_empty ? stg_ent[LATENCY] : fifo_head;
    assign rsp_data  = rsp_valid ? out_ent.dat : '0;
    assign rsp_tag   = rsp_valid ? out_ent.tag : '0;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Park the pipe tail unless it is consumed directly this cycle.
    assign fifo_push = stg_vld[LATENCY] && !(fifo_empty && rsp_ready);
    assign fifo_pop  = rsp_fire && !fifo_empty;

    // Byte-enabled storage writes; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_fire && !oob) begin
            for (int b = 0; b < WORD_SIZE; b++) begin
                if (req_byteen[b]) begin
                    mem[idx][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end

    // Read data pipeline: free-running, the valid bits decide which slots are live.
    always_ff @(posedge clk) begin
        stg_ent[1].tag <= req_tag;
        stg_ent[1].dat <= oob ? '0 : mem[idx];
        for (int i = 2; i <= LATENCY; i++) begin
            stg_ent[i] <= stg_ent[i-1];
        end
    end

    // Read valid pipeline; never stalls because the FIFO always has room for every outstanding read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_vld <= '0;
        end else begin
            stg_vld[1] <= rd_fire;
            for (int i = 2; i <= LATENCY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
            end
        end
    end

    // Live read count: up on read accept, down on response accept, unchanged when both happen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else begin
            case ({rd_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky flag for any accepted request that addressed beyond the storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oob_err <= 1'b0;
        end else if (req_valid && req_ready && oob) begin
            oob_err <= 1'b1;
        end
    end

    vx_imem_fifo #(
        .WIDTH ($bits(rsp_ent_t)),
        .DEPTH (RSP_QUEUE)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push_vld (fifo_push),
        .push_dat (stg_ent[LATENCY]),
        .pop_vld  (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty)
    );

    a_cnt_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(rd_fire && !rsp_fire && outstanding == CW'(RSP_QUEUE)));
    a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_fire && !rd_fire && outstanding == '0));
endmodule

// File: tb/tb_vx_imem_responder.sv
// Bench for vx_imem_responder with default parameters.
// Expected responses are queued at read acceptance and compared on every response fire.
// Drives inputs 1ns after the rising edge, samples on the falling edge.
module tb_vx_imem_responder;
    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_rw;
    logic [29:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_data;
    logic [7:0]  req_tag;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic        rsp_ready;
    logic [2:0]  outstanding;
    logic        oob_err;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    exp_t        sbq [$];
    logic [31:0] model [1024];

    logic        stalled = 1'b0;
    logic [31:0] hold_d;
    logic [7:0]  hold_t;
    exp_t        e_m;

    vx_imem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_byteen  (req_byteen),
        .req_data    (req_data),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_tag     (rsp_tag),
        .rsp_ready   (rsp_ready),
        .outstanding (outstanding),
        .oob_err     (oob_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Response monitor: order/data scoreboard, stall stability and idle-zero outputs.
    always @(negedge clk) begin
        if (!reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== hold_d || rsp_tag !== hold_t) begin
                    errors++;
                    $display("FAIL rsp_hold: got v=%b d=%h t=%h, expected v=1 d=%h t=%h",
                             rsp_valid, rsp_data, rsp_tag, hold_d, hold_t);
                end
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got d=%h t=%h, expected no response", rsp_data, rsp_tag);
                end else begin
                    e_m = sbq.pop_front();
                    if (rsp_data !== e_m.data || rsp_tag !== e_m.tag) begin
                        errors++;
                        $display("FAIL rsp_order: got d=%h t=%h, expected d=%h t=%h",
                                 rsp_data, rsp_tag, e_m.data, e_m.tag);
                    end
                end
            end else if (rsp_valid !== 1'b1) begin
                checks++;
                if (rsp_data !== 32'h0 || rsp_tag !== 8'h0) begin
                    errors++;
                    $display("FAIL rsp_idle_zero: got d=%h t=%h, expected 0 0", rsp_data, rsp_tag);
                end
            end
            stalled = (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
            hold_d  = rsp_data;
            hold_t  = rsp_tag;
        end
    end

    task automatic send_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        logic acc;
        req_valid  = 1'b1;
        req_rw     = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_byteen = be;
        req_tag    = 8'h0;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL write_accept: got req_ready=%b, expected 1 (addr %h)", acc, a);
        end else if (a < 30'd1024) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[a[9:0]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic send_read(input logic [29:0] a, input logic [7:0] t);
        logic acc;
        exp_t e;
        req_valid  = 1'b1;
        req_rw     = 1'b0;
        req_addr   = a;
        req_tag    = t;
        req_byteen = 4'h0;
        req_data   = 32'h0;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (acc === 1'b1) begin
            e.tag  = t;
            e.data = (a >= 30'd1024) ? 32'h0 : model[a[9:0]];
            sbq.push_back(e);
            n_acc++;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d pending responses, expected 0", name, sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd0) begin
            errors++;
            $display("FAIL drain_cnt_%s: got outstanding=%0d, expected 0", name, outstanding);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || outstanding !== 3'd0 || oob_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b out=%0d oob=%b rdy=%b, expected 0 0 0 1",
                     rsp_valid, outstanding, oob_err, req_ready);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send_write(30'd5, 32'h0000_0013, 4'hF);
        send_read(30'd5, 8'h21);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: got rsp_valid=%b at t+1, expected 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL lat_t2: got rsp_valid=%b at t+2, expected 1", rsp_valid);
        end
        wait_drain("basic");
    endtask

    task automatic test_byteen();
        send_write(30'd7, 32'hAABB_CCDD, 4'hF);
        send_write(30'd7, 32'h0000_1100, 4'h2);
        send_read(30'd7, 8'h27);
        checks++;
        if (model[7] !== 32'hAABB_11DD) begin
            errors++;
            $display("FAIL byteen_model: got %h, expected aabb11dd", model[7]);
        end
        wait_drain("byteen");
    endtask

    task automatic test_throughput();
        int  cons;
        int  maxo;
        bit  started;
        bit  done;
        for (int i = 0; i < 16; i++) begin
            send_write(30'(i), 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203), 4'hF);
        end
        rsp_ready = 1'b1;
        cons    = 0;
        maxo    = 0;
        started = 1'b0;
        done    = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send_read(30'(i), 8'h80 + 8'(i));
                end
            end
            begin
                for (int c = 0; c < 40 && !done; c++) begin
                    @(negedge clk);
                    if (int'(outstanding) > maxo) maxo = int'(outstanding);
                    if (!started) begin
                        if (rsp_valid === 1'b1) begin
                            started = 1'b1;
                            cons    = 1;
                        end
                    end else if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                        cons++;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
        join
        checks++;
        if (cons != 16) begin
            errors++;
            $display("FAIL stream_consecutive: got %0d back-to-back responses, expected 16", cons);
        end
        checks++;
        if (maxo > 2) begin
            errors++;
            $display("FAIL stream_outstanding: got max outstanding %0d, expected at most 2", maxo);
        end
        wait_drain("stream");
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send_read(30'(i), 8'h40 + 8'(i));
        end
        @(negedge clk);
        checks++;
        if (n_acc != 4) begin
            errors++;
            $display("FAIL bp_accepted: got %0d accepted reads, expected 4", n_acc);
        end
        checks++;
        if (req_ready !== 1'b0 || outstanding !== 3'd4) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b out=%0d, expected rdy=0 out=4", req_ready, outstanding);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_bypass: got req_ready=%b in first rsp fire cycle, expected 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_reopen: got req_ready=%b after first rsp fire, expected 1", req_ready);
        end
        wait_drain("bp");
    endtask

    task automatic test_oob();
        checks++;
        if (oob_err !== 1'b0) begin
            errors++;
            $display("FAIL oob_clear: got oob_err=%b before any out-of-range access, expected 0", oob_err);
        end
        send_read(30'h400, 8'h03);
        wait_drain("oob_read");
        checks++;
        if (oob_err !== 1'b1) begin
            errors++;
            $display("FAIL oob_set: got oob_err=%b, expected 1", oob_err);
        end
        send_write(30'h405, 32'hDEAD_BEEF, 4'hF);
        send_read(30'd5, 8'h22);
        wait_drain("oob_alias");
        repeat (5) @(negedge clk);
        checks++;
        if (oob_err !== 1'b1) begin
            errors++;
            $display("FAIL oob_sticky: got oob_err=%b, expected 1", oob_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        send_read(30'd1, 8'h61);
        send_read(30'd2, 8'h62);
        send_read(30'd3, 8'h63);
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd3) begin
            errors++;
            $display("FAIL rst_pre: got outstanding=%0d, expected 3", outstanding);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || outstanding !== 3'd0 || req_ready !== 1'b1 || oob_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b out=%0d rdy=%b oob=%b, expected 0 0 1 0",
                     rsp_valid, outstanding, req_ready, oob_err);
        end
        sbq.delete();
        repeat (2) @(posedge clk);
        #3;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        send_read(30'd5, 8'h55);
        send_read(30'd7, 8'h57);
        wait_drain("rst_keep");
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_rw     = 1'b0;
        req_addr   = '0;
        req_byteen = '0;
        req_data   = '0;
        req_tag    = '0;
        rsp_ready  = 1'b1;

        test_reset();
        test_basic();
        test_byteen();
        test_throughput();
        test_backpressure();
        test_oob();
        test_reset_mid();

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending responses, expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
